// File: rtl/video_pkg.sv
// video_pkg: framebuffer defaults, RGB565 field positions and the writer state encoding
// shared by the video memory requesters.
package video_pkg;
    localparam logic [24:0] FB_BASE_DEF  = 25'd0;
    localparam int          FB_WORDS_DEF = 307200;
    localparam int R_MSB = 15, R_LSB = 11, G_MSB = 10, G_LSB = 5, B_MSB = 4, B_LSB = 0;
    typedef enum logic [1:0] {IDLE, FILL, REQ, DATA} wr_state_t;
    function automatic int ptr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/wr_burst_buf.sv
// wr_burst_buf: NW-word staging buffer; filled from the pixel stream, drained by the
// controller's data strobes. rdata always shows the word at the read pointer.
module wr_burst_buf
    import video_pkg::*;
#(
    parameter int NW = 2
) (
    input  logic        mem_clock,
    input  logic        reset,
    input  logic        push,
    input  logic        restart,
    input  logic [31:0] wdata,
    input  logic        pop,
    output logic [31:0] rdata,
    output logic        fill_last,
    output logic        rd_last
);
    localparam int PW = ptr_w(NW);
    localparam int CW = ptr_w(NW + 1);
    logic [31:0]   mem [NW];
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_idx;
    assign wr_idx    = restart ? '0 : PW'(count);
    assign rdata     = mem[rd_ptr];
    assign fill_last = count == CW'(NW - 1);
    assign rd_last   = rd_ptr == PW'(NW - 1);
    always_ff @(posedge mem_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NW; i++) mem[i] <= '0;
            count  <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= wdata;
                count       <= restart ? CW'(1) : count + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_last ? '0 : rd_ptr + PW'(1);
                if (rd_last) count <= '0;
            end
        end
    end
endmodule

// File: rtl/videomem_wr_req.sv
// videomem_wr_req: collects packed RGB565 pixel pairs into SDRAM bursts and issues
// linear, frame-wrapping write requests to the sdrc_core application interface.
module videomem_wr_req
    import video_pkg::*;
#(
    parameter logic [24:0] FB_BASE   = FB_BASE_DEF,
    parameter int          FB_WORDS  = FB_WORDS_DEF,
    parameter int          BURST_LEN = 4
) (
    input  logic        mem_clock,
    input  logic        reset,
    input  logic        mem_ready,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_sof,
    output logic        in_ready,
    output logic        wr_request,
    output logic [24:0] wr_addr,
    output logic [8:0]  wr_len,
    input  logic        mem_req_ack,
    input  logic        give_next_data,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  drop_count
);
    localparam int          NW     = BURST_LEN / 2;
    localparam logic [25:0] FB_END = 26'(FB_BASE) + 26'(FB_WORDS);
    wr_state_t state, state_next;
    logic ack, push, restart, fills, pop, done, wrap, fill_last, rd_last;
    assign wr_len = 9'(BURST_LEN);
    assign busy   = state == REQ || state == DATA;
    assign wrap   = ({1'b0, wr_addr} + 26'(BURST_LEN)) >= FB_END;
    wr_burst_buf #(.NW(NW)) u_buf (
        .mem_clock(mem_clock),
        .reset(reset),
        .push(push),
        .restart(restart),
        .wdata(in_data),
        .pop(pop),
        .rdata(wr_data),
        .fill_last(fill_last),
        .rd_last(rd_last)
    );
    always_ff @(posedge mem_clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    // A data strobe in the ack cycle already consumes the first burst word.
    always_comb begin
        ack        = wr_request && mem_req_ack;
        in_ready   = !reset && (state == FILL || (state == IDLE && mem_ready));
        push       = in_valid && in_ready;
        restart    = push && in_sof && state == FILL;
        fills      = push && (restart ? NW == 1 : fill_last);
        pop        = give_next_data && (state == DATA || ack);
        done       = pop && rd_last;
        state_next = done ? IDLE : ack ? DATA : fills ? REQ : push ? FILL : state;
    end
    always_ff @(posedge mem_clock or posedge reset) begin
        if (reset) begin
            wr_addr    <= FB_BASE;
            wr_request <= 1'b0;
            frame_done <= 1'b0;
            drop_count <= '0;
        end else begin
            wr_request <= state == REQ && !ack && mem_ready;
            frame_done <= done && wrap;
            if (push && in_sof) wr_addr <= FB_BASE;
            else if (done) wr_addr <= wrap ? FB_BASE : wr_addr + 25'(BURST_LEN);
            if (restart && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: doc/videomem_wr_req.md
Name: videomem_wr_req

Overview:
- Write-side counterpart of the video memory read requester.
- Accepts a 32-bit stream of packed RGB565 pixel pairs from the host/USB side (valid/ready), collects it into SDRAM bursts, and issues write requests on the sdrc_core application interface (app_req / app_req_ack / app_wr_next_req).
- The framebuffer address advances linearly and wraps at the frame end, so streamed frames land where the read requester scans them out.

Parameters:
- FB_BASE, 25'd0: framebuffer start address, in 16-bit SDRAM word units.
- FB_WORDS, 307200: frame size in 16-bit words (640x480 RGB565).
- BURST_LEN, 4: burst length in 16-bit words; must be even, 2..16. A burst is BURST_LEN/2 application words.

Ports:
- mem_clock  in  1: memory clock; everything is on its rising edge.
- reset  in  1: asynchronous, active-high.
- mem_ready  in  1: SDRAM init done and bus granted to this writer. No new request starts while it is low.
- in_valid  in  1: input word valid.
- in_data  in  32: [15:0] is the first pixel, [31:16] the second.
- in_sof  in  1: qualifies in_valid; this word is the first word of a new frame.
- in_ready  out  1: word accepted on a cycle where in_valid and in_ready are both high.
- wr_request  out  1: write request to the controller.
- wr_addr  out  25: burst start address.
- wr_len  out  9: constant BURST_LEN.
- mem_req_ack  in  1: controller accepted the request.
- give_next_data  in  1: controller consumes wr_data this cycle.
- wr_data  out  32: current burst word.
- busy  out  1: high in any state other than IDLE and FILL.
- frame_done  out  1: one-cycle pulse after the last burst of a frame is written.
- drop_count  out  8: number of partial bursts discarded on a frame restart; saturates at 255.

Behaviour:
- Reset values: in_ready=0, wr_request=0, wr_addr=FB_BASE, wr_data=0, busy=0, frame_done=0, drop_count=0. Internal state: count=0, rd_ptr=0, state=IDLE.
- Buffer: NW=BURST_LEN/2 words, register array. wr_ptr and count are used while filling; rd_ptr is used while draining.
- IDLE: in_ready=mem_ready.
  - Accepted word: store at index 0, count=1.
  - If in_sof is high, addr=FB_BASE.
  - Go to FILL (or straight to REQ if NW==1).
- FILL: in_ready=1.
  - Each accepted word is stored at index count, and count increments.
  - When count reaches NW, go to REQ next cycle.
  - in_sof while count>0: discard the partial words, increment drop_count, set addr=FB_BASE, store the word at index 0, count=1.
- REQ: in_ready=0.
  - wr_request is registered and rises the cycle after entry, but only when mem_ready=1.
  - wr_addr is stable throughout REQ.
  - When mem_req_ack is sampled high with wr_request high: wr_request=0 on that edge, go to DATA.
  - If mem_ready falls before ack: drop wr_request and hold in REQ. Buffer and address are kept.
- DATA: wr_data = buf[rd_ptr] combinationally.
  - On give_next_data: rd_ptr increments.
  - On the give_next_data that consumes word NW-1: rd_ptr=0, count=0, addr += BURST_LEN, go to IDLE.
  - give_next_data in the ack cycle itself counts as a consume.
- Address wrap: when addr+BURST_LEN >= FB_BASE+FB_WORDS, addr wraps to FB_BASE and frame_done pulses one cycle together with the IDLE transition. FB_WORDS must be a multiple of BURST_LEN.
- give_next_data outside REQ-ack/DATA is ignored. mem_req_ack while wr_request=0 is ignored.
- in_valid while in_ready=0 is not consumed; the source holds the word.
- Reset asserted mid-burst: immediate return to reset values. The controller-side burst is abandoned, and the top level must reset sdrc_core together with this block.
- Throughput ceiling: 1 word per cycle while filling. Filling and draining are not overlapped.

Decomposition:
- Shared package video_pkg:
  - FB_BASE/FB_WORDS defaults
  - the RGB565 field positions used by the output path
  - the state encoding localparams (IDLE, FILL, REQ, DATA)
- One natural sub-module, wr_burst_buf: the NW-deep register array with write index/count, read pointer, and full/empty flags. The FSM and address counter stay in videomem_wr_req.

Test Plan:
- Basic burst: reset, mem_ready=1, stream 2 words 0x11112222, 0x33334444 with the first flagged in_sof. Expect wr_request with wr_addr=0 and wr_len=4. Controller acks, then 2 give_next_data present those two words in order. Next burst wr_addr=4.
- Backpressure: hold mem_req_ack low for 20 cycles. Expect in_ready=0, wr_request high, wr_addr stable; in_valid words are not lost; data is correct after ack.
- mem_ready drop: deassert mem_ready in REQ before ack. Expect wr_request to fall; on re-assert the same wr_addr and data are requested again.
- Frame wrap: FB_WORDS=16, stream 8 words. Expect addresses 0,4,8,12, then frame_done one pulse, then next address 0.
- SOF restart: send 1 word, then a word with in_sof. Expect drop_count=1 and the next request at FB_BASE containing the sof word first.
- Async reset mid-DATA: assert reset after 1 give_next_data. Expect wr_request=0, in_ready=0, and a post-reset burst that starts cleanly at FB_BASE.
